add64_arbiter: RTL

Round-robin arbiter and sequencer that shares one pipelined 64-bit adder (`adder64`, fixed latency, global enable stall) between `NREQ` requesters. It accepts at most one operand pair per cycle and tracks each in-flight operation's requester ID in a shadow pipeline aligned to the adder. It returns each sum to its originator through a valid/ready response port. Backpressure on any response stalls the whole adder pipeline. The block sits between the execution-unit issue ports and the shared adder instance, which it owns.

---
 rtl/add64_arbiter_pkg.sv | 30 +++
 rtl/add64_arbiter_if.sv | 36 +++
 rtl/add64_arbiter_adder64.sv | 45 ++++
 rtl/add64_arbiter_rr_arbiter.sv | 52 +++++
 rtl/add64_arbiter.sv | 132 +++++++++++++
 5 files changed

// File: rtl/add64_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add64_arbiter_pkg
// Description : Shared constants and helpers for the add64_arbiter block:
//               datapath width, adder latency and ID/counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package add64_arbiter_pkg;

   // Datapath width of the shared adder
   localparam int LEN_DATA = 64;

   // Adder stage count; the shadow pipeline depth must match it
   localparam int ADD_LAT = 10;

   // Ceiling log2, used for requester ID and in-flight counter widths
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

   // Width of the in-flight counter: must hold 0..ADD_LAT
   localparam int CNT_W = clog2(ADD_LAT + 1);

endpackage
`default_nettype wire

// File: rtl/add64_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : add64_arbiter_if
// Description : Request/response bundle between the issue ports and the
//               shared-adder arbiter. The slave modport is the arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface add64_arbiter_if
   import add64_arbiter_pkg::*;
#(
   parameter int NREQ = 4
);
   localparam int ID_W = clog2(NREQ);

   logic [NREQ-1:0]          req_valid;
   logic [NREQ-1:0]          req_ready;
   logic [NREQ*LEN_DATA-1:0] req_a;
   logic [NREQ*LEN_DATA-1:0] req_b;
   logic [NREQ-1:0]          rsp_valid;
   logic [NREQ-1:0]          rsp_ready;
   logic [LEN_DATA-1:0]      rsp_sum;
   logic [ID_W-1:0]          rsp_id;
   logic [CNT_W-1:0]         inflight;

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_sum, rsp_id, inflight
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_sum, rsp_id, inflight
   );

endinterface
`default_nettype wire

// File: rtl/add64_arbiter_adder64.sv
`default_nettype none
// ============================================================================
// Module      : adder64
// Description : Pipelined 64-bit adder with a global enable stall. The sum of
//               operands presented before an enabled edge appears ADD_LAT
//               enabled edges later. Carry-out is discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module adder64
   import add64_arbiter_pkg::*;
(
   input  wire logic                clk,
   input  wire logic                rst,
   input  wire logic                en,
   input  wire logic [LEN_DATA-1:0] a,
   input  wire logic [LEN_DATA-1:0] b,
   output logic      [LEN_DATA-1:0] sum,
   output logic                     rdy
);
   logic [LEN_DATA-1:0] r_stage [ADD_LAT];
   logic                r_rdy;

   // Add in the first stage, then carry the result down the delay stages
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ADD_LAT; i++) begin
            r_stage[i] <= '0;
         end
         r_rdy <= 1'b0;
      end else begin
         r_rdy <= 1'b1;
         if (en) begin
            r_stage[0] <= a + b;
            for (int i = 1; i < ADD_LAT; i++) begin
               r_stage[i] <= r_stage[i-1];
            end
         end
      end
   end

   assign sum = r_stage[ADD_LAT-1];
   assign rdy = r_rdy;

endmodule
`default_nettype wire

// File: rtl/add64_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Searches the request
//               vector cyclically starting at ptr; the pointer itself is held
//               by the parent.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  wire logic [NREQ-1:0] req,
   input  wire logic [ID_W-1:0] ptr,
   input  wire logic            en,
   output logic      [NREQ-1:0] grant,
   output logic      [ID_W-1:0] grant_id,
   output logic                 grant_any
);
   logic [2*NREQ-1:0] w_req2;
   logic [NREQ-1:0]   w_rot;

   // Rotate so that bit k is requester (ptr + k) mod NREQ
   assign w_req2 = {req, req} >> ptr;
   assign w_rot  = w_req2[NREQ-1:0];

   // Lowest rotated position wins; map it back to a requester index
   always_comb begin : p_arb
      int sel;
      sel       = 0;
      grant_any = 1'b0;
      grant     = '0;
      grant_id  = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            sel       = int'(ptr) + k;
            grant_any = en;
         end
      end
      if (sel >= NREQ) begin
         sel = sel - NREQ;
      end
      for (int i = 0; i < NREQ; i++) begin
         if (grant_any && (sel == i)) begin
            grant[i] = 1'b1;
            grant_id = ID_W'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/add64_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : add64_arbiter
// Description : Shares one pipelined 64-bit adder between NREQ requesters.
//               A round-robin grant feeds the adder; a shadow pipeline of
//               {vld, id} rides alongside it and routes each sum back.
//               A blocked result at the tail stalls the whole pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module add64_arbiter
   import add64_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int ID_W = clog2(NREQ)
) (
   input  wire logic      clk,
   input  wire logic      rst,
   add64_arbiter_if.slave bus
);
   logic [ID_W-1:0]     r_rr_ptr;
   logic                r_vld [ADD_LAT];
   logic [ID_W-1:0]     r_id  [ADD_LAT];
   logic [CNT_W-1:0]    r_inflight;

   logic                w_tail_vld;
   logic [ID_W-1:0]     w_tail_id;
   logic                w_add_en;
   logic                w_arb_en;
   logic                w_tail_done;
   logic [NREQ-1:0]     w_grant;
   logic [ID_W-1:0]     w_grant_id;
   logic                w_grant_any;
   logic [LEN_DATA-1:0] w_add_a;
   logic [LEN_DATA-1:0] w_add_b;
   logic [LEN_DATA-1:0] w_sum;
   logic [NREQ-1:0]     w_rsp_valid;

   assign w_tail_vld  = r_vld[ADD_LAT-1];
   assign w_tail_id   = r_id[ADD_LAT-1];
   // The pipeline only stalls when the tail holds a result nobody will take
   assign w_add_en    = !(w_tail_vld && !bus.rsp_ready[w_tail_id]);
   assign w_arb_en    = w_add_en && !rst;
   assign w_tail_done = w_tail_vld && bus.rsp_ready[w_tail_id] && w_add_en;

   rr_arbiter #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) u_rr_arbiter (
      .req       (bus.req_valid),
      .ptr       (r_rr_ptr),
      .en        (w_arb_en),
      .grant     (w_grant),
      .grant_id  (w_grant_id),
      .grant_any (w_grant_any)
   );

   // Select the granted operand pair; zero operands form a bubble
   always_comb begin
      w_add_a = '0;
      w_add_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_add_a = w_add_a | bus.req_a[i*LEN_DATA +: LEN_DATA];
            w_add_b = w_add_b | bus.req_b[i*LEN_DATA +: LEN_DATA];
         end
      end
   end

   // Ready is not needed: the shadow pipeline already tracks validity
   adder64 u_adder64 (
      .clk (clk),
      .rst (rst),
      .en  (w_add_en),
      .a   (w_add_a),
      .b   (w_add_b),
      .sum (w_sum),
      .rdy ()
   );

   // Shadow pipeline advances in lockstep with the adder enable
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ADD_LAT; i++) begin
            r_vld[i] <= 1'b0;
            r_id[i]  <= '0;
         end
      end else if (w_add_en) begin
         r_vld[0] <= w_grant_any;
         r_id[0]  <= w_grant_id;
         for (int i = 1; i < ADD_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_id[i]  <= r_id[i-1];
         end
      end
   end

   // Round-robin pointer moves past the most recent winner
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr <= '0;
      end else if (w_grant_any) begin
         r_rr_ptr <= (w_grant_id == ID_W'(NREQ - 1)) ? '0 : w_grant_id + 1'b1;
      end
   end

   // In-flight count: grant adds one, a taken tail result removes one
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inflight <= '0;
      end else if (w_grant_any && !w_tail_done) begin
         r_inflight <= r_inflight + 1'b1;
      end else if (!w_grant_any && w_tail_done) begin
         r_inflight <= r_inflight - 1'b1;
      end
   end

   // Decode the tail owner into a one-hot response valid
   always_comb begin
      w_rsp_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_rsp_valid[i] = w_tail_vld && (w_tail_id == ID_W'(i));
      end
   end

   assign bus.req_ready = w_grant;
   assign bus.rsp_valid = w_rsp_valid;
   assign bus.rsp_sum   = w_sum;
   assign bus.rsp_id    = w_tail_id;
   assign bus.inflight  = r_inflight;

endmodule
`default_nettype wire
